load_store_unit: RTL and testbench

- Multi-cycle data-memory access stage directly upstream of the memory data register.
- Accepts one load/store command per transaction and drives a word-organised data memory through a req/ack handshake with byte enables.
- Aligns and sign/zero-extends load data.
- rdata is the value the memory data register captures; done is the capture qualifier.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_load_align.sv | 42 ++++
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module  : lsu_pkg
//  Brief   : Shared encodings and helpers for the load/store unit.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (size)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Offset with the bits the access size cannot address forced to zero.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] r;
        r = off;
        case (size)
            SZ_HALF: r = {off[1], 1'b0};
            SZ_WORD: r = 2'b00;
            default: r = off;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] r;
        r = 4'b0000;
        case (size)
            SZ_BYTE: r = 4'b0001 << off;
            SZ_HALF: r = 4'b0011 << {off[1], 1'b0};
            SZ_WORD: r = BE_WORD;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
//  Module  : lsu_load_align
//  Brief   : Extracts the addressed byte/half lane and sign/zero-extends it.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        result = 32'h0000_0000;
        case (addr)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size)
            SZ_BYTE: result = {{24{sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: result = {{16{sign_ext & w_half[15]}}, w_half};
            SZ_WORD: result = mem_rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module  : load_store_unit
//  Brief   : Multi-cycle load/store stage with req/ack memory handshake.
//            MISALIGN_CHECK_EN: when defined, misaligned half/word accesses
//            error; otherwise low address bits are truncated.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t          state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                is_store_q, is_store_d;
    logic [1:0]          size_q, size_d;
    logic                sign_ext_q, sign_ext_d;
    logic [1:0]          lane_q, lane_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                w_bad_cmd;
    logic [1:0]          w_lane;
    logic [31:0]         w_load_data;

    `ifdef MISALIGN_CHECK_EN
    assign w_bad_cmd = (size == SZ_ILLEGAL) || is_misaligned(size, addr[1:0]);
    `else
    assign w_bad_cmd = (size == SZ_ILLEGAL);
    `endif

    assign w_lane = eff_offset(size, addr[1:0]);

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .addr      (lane_q),
        .size      (size_q),
        .sign_ext  (sign_ext_q),
        .result    (w_load_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        sign_ext_d  = sign_ext_q;
        lane_d      = lane_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    lane_d     = w_lane;
                    busy_d     = 1'b1;
                    if (w_bad_cmd) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = addr[ADDR_W-1:2];
                        mem_be_d    = byte_enables(size, w_lane);
                        case (size)
                            SZ_BYTE: mem_wdata_d = {4{wdata[7:0]}};
                            SZ_HALF: mem_wdata_d = {2{wdata[15:0]}};
                            default: mem_wdata_d = wdata;
                        endcase
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    if (!is_store_q) begin
                        rdata_d = w_load_data;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == c_cnt_last)) begin
                    state_d   = ST_ERR;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            default: begin
                // DONE and ERR both last exactly one cycle.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            size_q      <= 2'b00;
            sign_ext_q  <= 1'b0;
            lane_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            sign_ext_q  <= sign_ext_d;
            lane_q      <= lane_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module  : tb_load_store_unit
//  Brief   : Directed self-checking bench for load_store_unit.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clock;
    logic              rst;
    logic              start;
    logic              is_store;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_rdata;

    load_store_unit #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        start    = 1'b1;
        is_store = st;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        // 1: reset with random inputs
        rst       = 1'b0;
        start     = 1'($urandom);
        is_store  = 1'($urandom);
        size      = 2'($urandom);
        sign_ext  = 1'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        repeat (3) tick();
        check("rst_ctrl", {26'd0, busy, done, err, mem_req, mem_we, 1'b0}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", {2'b00, mem_addr}, 32'h0);
        check("rst_be", {28'd0, mem_be}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        start   = 1'b0;
        mem_ack = 1'b0;
        rst     = 1'b1;
        repeat (2) tick();
        check("idle_busy", {31'd0, busy}, 32'h0);
        check("idle_req", {31'd0, mem_req}, 32'h0);

        // 2: signed byte load, two wait cycles
        mem_rdata = 32'h80AA_BBCC;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        check("ld_b_req", {31'd0, mem_req}, 32'h1);
        check("ld_b_busy", {31'd0, busy}, 32'h1);
        check("ld_b_we", {31'd0, mem_we}, 32'h0);
        check("ld_b_be", {28'd0, mem_be}, 32'h8);
        check("ld_b_addr", {2'b00, mem_addr}, 32'h40);
        tick();
        tick();
        check("ld_b_nodone", {31'd0, done}, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ld_b_done", {30'd0, done, err}, 32'h2);
        check("ld_b_rdata", rdata, 32'hFFFF_FF80);
        check("ld_b_reqlow", {31'd0, mem_req}, 32'h0);
        tick();
        check("ld_b_pulse", {30'd0, done, busy}, 32'h0);
        exp_rdata = 32'hFFFF_FF80;

        // 3: half store, zero-wait ack
        mem_rdata = 32'hDEAD_BEEF;
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_1234);
        check("st_h_we", {31'd0, mem_we}, 32'h1);
        check("st_h_be", {28'd0, mem_be}, 32'hC);
        check("st_h_wdata", mem_wdata, 32'h1234_1234);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st_h_done", {30'd0, done, err}, 32'h2);
        check("st_h_rdata", rdata, exp_rdata);
        tick();

        // 4: misaligned word load
        mem_rdata = 32'hCAFE_F00D;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0);
`ifdef MISALIGN_CHECK_EN
        check("ld_w_req", {31'd0, mem_req}, 32'h0);
        check("ld_w_doneerr", {30'd0, done, err}, 32'h3);
        tick();
        check("ld_w_rdata", rdata, exp_rdata);
`else
        check("ld_w_req", {31'd0, mem_req}, 32'h1);
        check("ld_w_be", {28'd0, mem_be}, 32'hF);
        check("ld_w_addr", {2'b00, mem_addr}, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ld_w_done", {30'd0, done, err}, 32'h2);
        check("ld_w_rdata", rdata, 32'hCAFE_F00D);
        exp_rdata = 32'hCAFE_F00D;
        tick();
`endif

        // 5: timeout after 4 REQ cycles, second start ignored
        mem_rdata = 32'h0000_0011;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_req%0d", i), {30'd0, mem_req, done}, 32'h2);
            if (i == 1) begin
                start    = 1'b1;
                is_store = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("to_reqlow", {31'd0, mem_req}, 32'h0);
        check("to_doneerr", {30'd0, done, err}, 32'h3);
        check("to_rdata", rdata, exp_rdata);
        tick();
        check("to_idle", {29'd0, busy, done, mem_req}, 32'h0);
        tick();
        check("to_noqueue", {29'd0, busy, done, mem_req}, 32'h0);

        // 6: asynchronous reset mid-REQ, then zero-extended byte load
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0006, 32'h0);
        check("ar_req", {31'd0, mem_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("ar_async", {30'd0, mem_req, busy}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("ar_nodone", {30'd0, done, busy}, 32'h0);
        tick();
        check("ar_nodone2", {31'd0, done}, 32'h0);
        mem_rdata = 32'h00FF_0000;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0);
        check("zx_be", {28'd0, mem_be}, 32'h4);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("zx_done", {30'd0, done, err}, 32'h2);
        check("zx_rdata", rdata, 32'h0000_00FF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
